// File: rtl/xpb_reduce_accum.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_reduce_accum
//  Description : Sequential xpb reduction accumulator. Each transaction loads
//                the low WIDTH bits of a wide square into a guard-extended
//                accumulator. It then walks NUM_SEG overflow segments, one per
//                cycle: each segment is driven as an address to the external
//                LUT mux, and the returned residue is added to the accumulator.
//  Options     : XPB_LUT_REG_EN - register lut_data before the adder. This adds
//                one drain cycle and leaves the results unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module xpb_reduce_accum #(
    parameter int WIDTH   = 1024,
    parameter int SEG_W   = 5,
    parameter int NUM_SEG = 8,
    parameter int GUARD   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_base,
    input  logic [NUM_SEG*SEG_W-1:0]    in_seg,
    output logic [$clog2(NUM_SEG)-1:0]  lut_seg,
    output logic [SEG_W-1:0]            lut_addr,
    input  logic [WIDTH-1:0]            lut_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH+GUARD-1:0]      out_sum,
    output logic                        busy
);

    localparam int c_idx_w = $clog2(NUM_SEG);
    localparam int c_cnt_w = $clog2(NUM_SEG + 1);
    localparam int c_acc_w = WIDTH + GUARD;

    // Value of the counter on the final ACCUM cycle. With the registered LUT
    // path, the last add happens one cycle after the last address.
`ifdef XPB_LUT_REG_EN
    localparam logic [c_cnt_w-1:0] c_cnt_end = c_cnt_w'(NUM_SEG);
`else
    localparam logic [c_cnt_w-1:0] c_cnt_end = c_cnt_w'(NUM_SEG - 1);
`endif
    localparam logic [c_cnt_w-1:0] c_num_seg = c_cnt_w'(NUM_SEG);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_acc_w-1:0] r_acc;
    logic [SEG_W-1:0]   r_seg [NUM_SEG];
    logic [WIDTH-1:0]   w_addend;
    logic               w_accept;
    logic               w_addr_phase;

    assign w_accept     = in_valid && (r_state == c_st_idle);
    // Addresses are presented only while segments remain. The drain cycle of
    // the registered path presents address 0.
    assign w_addr_phase = (r_state == c_st_accum) && (r_cnt < c_num_seg);

`ifdef XPB_LUT_REG_EN
    logic [WIDTH-1:0] r_lut_q;

    // Capture the LUT return. Zero outside the address phase, so the drain
    // cycle adds nothing spurious.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lut_q <= '0;
        end else if (w_accept) begin
            r_lut_q <= '0;
        end else if (r_state == c_st_accum) begin
            r_lut_q <= w_addr_phase ? lut_data : '0;
        end
    end

    assign w_addend = r_lut_q;
`else
    assign w_addend = lut_data;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> ACCUM -> DONE -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (in_valid)          w_next = c_st_accum;
            c_st_accum: if (r_cnt == c_cnt_end) w_next = c_st_done;
            c_st_done:  if (out_ready)         w_next = c_st_idle;
            default:                           w_next = c_st_idle;
        endcase
    end

    // Output decode; LUT select/address are held at zero outside the address phase
    always_comb begin
        in_ready  = (r_state == c_st_idle);
        busy      = (r_state == c_st_accum) || (r_state == c_st_done);
        out_valid = (r_state == c_st_done);
        out_sum   = (r_state == c_st_done) ? r_acc : '0;
        lut_seg   = '0;
        lut_addr  = '0;
        if (w_addr_phase) begin
            lut_seg  = r_cnt[c_idx_w-1:0];
            lut_addr = r_seg[r_cnt[c_idx_w-1:0]];
        end
    end

    // Datapath: load base and segments on accept, accumulate once per ACCUM cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            for (int k = 0; k < NUM_SEG; k++) begin
                r_seg[k] <= '0;
            end
        end else if (w_accept) begin
            r_cnt <= '0;
            r_acc <= {{GUARD{1'b0}}, in_base};
            for (int k = 0; k < NUM_SEG; k++) begin
                r_seg[k] <= in_seg[k*SEG_W +: SEG_W];
            end
        end else if (r_state == c_st_accum) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            r_acc <= r_acc + {{GUARD{1'b0}}, w_addend};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xpb_reduce_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xpb_reduce_accum
//  Description : Self-checking bench for xpb_reduce_accum. It models the xpb
//                LUT as LUT[k][a] = a*(k+1)*0x10001. Expected sums come from
//                a plain arithmetic reference of base + sum of LUT terms.
//                Honours XPB_LUT_REG_EN for the expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_reduce_accum;

    localparam int WIDTH   = 1024;
    localparam int SEG_W   = 5;
    localparam int NUM_SEG = 8;
    localparam int GUARD   = 4;
    localparam int SW      = NUM_SEG * SEG_W;
    localparam int AW      = WIDTH + GUARD;
`ifdef XPB_LUT_REG_EN
    localparam int EXP_LAT = NUM_SEG + 2;
`else
    localparam int EXP_LAT = NUM_SEG + 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_base;
    logic [SW-1:0]     in_seg;
    logic [2:0]        lut_seg;
    logic [SEG_W-1:0]  lut_addr;
    logic [WIDTH-1:0]  lut_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_sum;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    xpb_reduce_accum #(
        .WIDTH(WIDTH), .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .GUARD(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_seg(in_seg),
        .lut_seg(lut_seg), .lut_addr(lut_addr), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    always #5 clk = ~clk;

    // External LUT model with a combinational return
    always_comb begin
        lut_data = WIDTH'(32'(lut_addr) * (32'(lut_seg) + 32'd1) * 32'h10001);
    end

    // Record the LUT requests made while a transaction is accumulating
    logic [2:0]       mon_seg  [$];
    logic [SEG_W-1:0] mon_addr [$];
    always @(negedge clk) begin
        if (busy && !out_valid) begin
            mon_seg.push_back(lut_seg);
            mon_addr.push_back(lut_addr);
        end
    end

    function automatic logic [AW-1:0] ref_sum(input logic [WIDTH-1:0] base, input logic [SW-1:0] seg);
        logic [AW-1:0] s;
        s = AW'(base);
        for (int k = 0; k < NUM_SEG; k++) begin
            s = s + AW'(32'(seg[k*SEG_W +: SEG_W]) * 32'(k + 1) * 32'h10001);
        end
        return s;
    endfunction

    function automatic string short_hex(input logic [AW-1:0] v);
        return $sformatf("%h..%h", v[AW-1:AW-64], v[63:0]);
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s want %s", name, short_hex(act), short_hex(exp));
        end
    endtask

    // Offer one transaction, wait for the result and return it.
    // lat counts posedges with the accept edge numbered 1.
    task automatic run_txn(input logic [WIDTH-1:0] base, input logic [SW-1:0] seg,
                           input int rdy_delay, output logic [AW-1:0] sum, output int lat);
        bit accepted = 0;
        sum = '0;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_base  = base;
        in_seg   = seg;
        for (int t = 0; t < 20 && !accepted; t++) begin
            if (in_ready) begin
                @(posedge clk);
                accepted = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) begin
            chk("result_timeout", 0, 1);
            return;
        end
        sum = out_sum;
        for (int d = 0; d < rdy_delay; d++) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [WIDTH-1:0] base;
        logic [SW-1:0]    seg;
        logic [AW-1:0]    exp_sum;
    } vec_t;

    vec_t tv [3];

    initial begin
        logic [AW-1:0] sum;
        logic [AW-1:0] exp;
        logic [AW-1:0] hold;
        logic [WIDTH-1:0] b;
        logic [SW-1:0] s;
        int lat;

        // Directed vectors with hand-derived sums
        tv[0].base = WIDTH'(16'h1234);
        tv[0].seg  = '0;
        tv[0].exp_sum = AW'(16'h1234);
        tv[1].base = {WIDTH{1'b1}};
        tv[1].seg  = {SW{1'b1}};
        tv[1].exp_sum = {{GUARD{1'b0}}, {WIDTH{1'b1}}} + AW'(32'd73139292);
        tv[2].base = WIDTH'(32'hCAFE_0000);
        for (int k = 0; k < NUM_SEG; k++) tv[2].seg[k*SEG_W +: SEG_W] = SEG_W'(k + 1);
        tv[2].exp_sum = AW'(32'hCAFE_0000) + AW'(32'd13369548);

        in_valid = 1'b0; in_base = '0; in_seg = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", AW'(out_valid), 0);
        chk("rst_busy",      AW'(busy), 0);
        chk("rst_out_sum",   out_sum, 0);
        chk("rst_lut_seg",   AW'(lut_seg), 0);
        chk("rst_lut_addr",  AW'(lut_addr), 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_in_ready", AW'(in_ready), 1);

        // Table-driven directed transactions
        for (int i = 0; i < 3; i++) begin
            mon_seg.delete();
            mon_addr.delete();
            run_txn(tv[i].base, tv[i].seg, i, sum, lat);
            chk($sformatf("vec%0d_sum", i), sum, tv[i].exp_sum);
            chk($sformatf("vec%0d_latency", i), AW'(lat), AW'(EXP_LAT));
            if (i == 1) chk("vec1_guard_nonzero", AW'(sum[AW-1:WIDTH] != 0), 1);
            if (i == 2) begin
                chk("vec2_lut_cycles", AW'(mon_seg.size()), AW'(EXP_LAT - 1));
                for (int k = 0; k < NUM_SEG && k < mon_seg.size(); k++) begin
                    chk($sformatf("vec2_lut_seg%0d", k), AW'(mon_seg[k]), AW'(k));
                    chk($sformatf("vec2_lut_addr%0d", k), AW'(mon_addr[k]), AW'(k + 1));
                end
            end
        end

        // Result held in DONE while out_ready is low, new offers ignored
        b = WIDTH'(64'h0123_4567_89AB_CDEF);
        s = 40'h21_0843_1A5F;
        exp = ref_sum(b, s);
        @(negedge clk);
        in_valid = 1'b1; in_base = b; in_seg = s;
        @(posedge clk);
        #1 in_valid = 1'b1; in_base = ~b; in_seg = ~s;
        for (int t = 0; t < 30 && !out_valid; t++) @(posedge clk) #1;
        chk("stall_reached_done", AW'(out_valid), 1);
        hold = out_sum;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk) #1;
            chk($sformatf("stall%0d_sum", c), out_sum, exp);
            chk($sformatf("stall%0d_valid", c), AW'(out_valid), 1);
            chk($sformatf("stall%0d_in_ready", c), AW'(in_ready), 0);
        end
        chk("stall_sum_first", hold, exp);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_release_valid", AW'(out_valid), 0);
        chk("stall_release_busy",  AW'(busy), 0);

        // Reset in the middle of accumulation aborts without output
        @(negedge clk);
        in_valid = 1'b1; in_base = b; in_seg = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", AW'(out_valid), 0);
        chk("midrst_busy",      AW'(busy), 0);
        chk("midrst_lut_addr",  AW'(lut_addr), 0);
        @(negedge clk) rst_n = 1'b1;
        run_txn(tv[2].base, tv[2].seg, 0, sum, lat);
        chk("midrst_next_sum", sum, tv[2].exp_sum);
        chk("midrst_next_lat", AW'(lat), AW'(EXP_LAT));

        // Randomized transactions against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int w = 0; w < WIDTH / 32; w++) b[w*32 +: 32] = $urandom;
            s = SW'({$urandom, $urandom});
            if (r == 0) b = {WIDTH{1'b1}};
            run_txn(b, s, int'($urandom_range(0, 3)), sum, lat);
            chk($sformatf("rand%0d_sum", r), sum, ref_sum(b, s));
            chk($sformatf("rand%0d_lat", r), AW'(lat), AW'(EXP_LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
